uart_byte_rx: RTL

UART_BYTE_RX -- requirements
Module: uart_byte_rx

---
 rtl/uart_byte_rx.sv | 125 ++++++++++++
 1 files changed

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver with a one-byte holding register and valid/yumi handshake.
// Flags a bad stop bit and a byte that completes while the holding register is still full.
module uart_byte_rx #(
    parameter int clk_per_bit_p = 10416
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       v_o,
    input  logic       yumi_i,
    output logic       frame_err_o,
    output logic       overrun_err_o
);

    localparam int cnt_w_lp = $clog2(clk_per_bit_p);
    localparam logic [cnt_w_lp-1:0] half_last_lp = cnt_w_lp'(clk_per_bit_p / 2 - 1);
    localparam logic [cnt_w_lp-1:0] full_last_lp = cnt_w_lp'(clk_per_bit_p - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic                rx_meta_p0;
    logic                rx_s;
    logic [1:0]          sync_fill;
    state_t              state;
    logic                armed;
    logic [cnt_w_lp-1:0] cnt;
    logic [2:0]          bit_idx;
    logic [7:0]          shift_r;

    // The bit counter holds at its last legal value instead of wrapping.
    function automatic logic [cnt_w_lp-1:0] sat_inc(input logic [cnt_w_lp-1:0] c);
        return (c == full_last_lp) ? c : c + cnt_w_lp'(1);
    endfunction

    // sync_fill marks when rx_s carries real line samples rather than reset values,
    // so a line held low across reset release is never mistaken for an idle-high line.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rx_meta_p0 <= 1'b1;
            rx_s       <= 1'b1;
            sync_fill  <= 2'b00;
        end else begin
            rx_meta_p0 <= rx_i;
            rx_s       <= rx_meta_p0;
            sync_fill  <= {sync_fill[0], 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state         <= IDLE;
            armed         <= 1'b0;
            cnt           <= '0;
            bit_idx       <= 3'd0;
            shift_r       <= 8'h00;
            data_o        <= 8'h00;
            v_o           <= 1'b0;
            frame_err_o   <= 1'b0;
            overrun_err_o <= 1'b0;
        end else begin
            frame_err_o   <= 1'b0;
            overrun_err_o <= 1'b0;
            if (yumi_i && v_o) begin
                v_o <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!armed) begin
                        armed <= sync_fill[1] && rx_s;
                    end else if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == half_last_lp) begin
                        cnt     <= '0;
                        bit_idx <= 3'd0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                DATA: begin
                    if (cnt == full_last_lp) begin
                        cnt              <= '0;
                        shift_r[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                STOP: begin
                    if (cnt == full_last_lp) begin
                        cnt   <= '0;
                        state <= IDLE;
                        armed <= 1'b0;
                        if (!rx_s) begin
                            frame_err_o <= 1'b1;
                        end else if (!v_o || yumi_i) begin
                            data_o <= shift_r;
                            v_o    <= 1'b1;
                        end else begin
                            overrun_err_o <= 1'b1;
                        end
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
